// File: rtl/adc_ram_readout.sv
// adc_ram_readout: reads a block of captured ADC words from the capture RAM
// read port and presents them as a valid/ready stream. A credit check against
// a small output FIFO absorbs the RAM read latency and downstream stalls.
//
// state | meaning
// IDLE  | waiting for rd_start; FIFO and tracker empty
// ISSUE | issuing RAM reads while credit is available
// DRAIN | all reads issued; waiting for the last handshake
module adc_ram_readout #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base_addr,
  input  logic [ADDR_W:0]   rd_length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [ADDR_W:0]       iss_cnt_q, iss_cnt_d;
  logic [ADDR_W:0]       acc_cnt_q, acc_cnt_d;
  logic [RD_LATENCY-1:0] trk_q, trk_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  done_q, done_d;

  logic [OCC_W-1:0]      inflight;
  logic [OCC_W:0]        used;
  logic                  credit;
  logic                  issue;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: buffered words plus reads still in the RAM pipe must fit the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(trk_q[i]);
    end
    used   = {1'b0, occ_q} + {1'b0, inflight};
    credit = used < (OCC_W + 1)'(DEPTH);
    push   = trk_q[RD_LATENCY-1];
    pop    = (occ_q != '0) && out_ready;
  end

  // Next-state, read issue, completion and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    iss_cnt_d = iss_cnt_q;
    acc_cnt_d = acc_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    mem_d     = mem_q;
    done_d    = 1'b0;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (rd_length == '0) begin
            done_d = 1'b1;
          end else begin
            // The start edge itself issues the first read at the base address.
            issue     = 1'b1;
            addr_d    = rd_base_addr;
            len_d     = rd_length;
            iss_cnt_d = LEN_ONE;
            acc_cnt_d = '0;
            state_d   = (rd_length == LEN_ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          issue     = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          iss_cnt_d = iss_cnt_q + LEN_ONE;
          if (iss_cnt_d == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      acc_cnt_d = acc_cnt_q + LEN_ONE;
      if (acc_cnt_d == len_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    trk_d    = trk_q << 1;
    trk_d[0] = issue;

    if (push) begin
      mem_d[wr_ptr_q] = ram_rd_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      iss_cnt_q <= '0;
      acc_cnt_q <= '0;
      trk_q     <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      iss_cnt_q <= iss_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      trk_q     <= trk_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ram_rd_addr = addr_q;
  assign out_valid   = (occ_q != '0);
  assign out_data    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_adc_ram_readout.sv
// Testbench for adc_ram_readout: random RAM contents, scoreboard of expected
// words per readout, separate monitor that pops and compares on handshakes.
module tb_adc_ram_readout;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_start;
  logic [AW-1:0] rd_base_addr;
  logic [AW:0]   rd_length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  adc_ram_readout #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .rd_start(rd_start),
    .rd_base_addr(rd_base_addr), .rd_length(rd_length),
    .busy(busy), .done(done), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Capture RAM: address registered at one edge, data out after the next.
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] ram_q;
  always @(posedge clk) ram_q <= mem[ram_rd_addr];
  assign ram_rd_data = ram_q;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rx_cnt = 0;
  bit mode = 1'b0;
  logic [DW-1:0] exp_q[$];
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_stall) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data", 64'(out_data), 64'(prev_data));
    end
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(out_valid), 64'(0));
      end else begin
        chk("word", 64'(out_data), 64'(exp_q.pop_front()));
        rx_cnt++;
      end
    end
    prev_stall = reset_n && out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic run(input int base, input int len, input bit rnd, input bit spur);
    int s;
    int dc0;
    bit got;
    mode = rnd;
    @(posedge clk);
    #1;
    rd_start     = 1'b1;
    rd_base_addr = AW'(base);
    rd_length    = (AW + 1)'(len);
    dc0 = done_cnt;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % 4096]);
    @(posedge clk);
    #1;
    rd_start     = 1'b0;
    rd_base_addr = AW'($urandom);
    rd_length    = (AW + 1)'($urandom_range(1, 100));
    @(negedge clk);
    if (len == 0) begin
      chk("zero_done", 64'(done), 64'(1));
      chk("zero_busy", 64'(busy), 64'(0));
      chk("zero_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("zero_done_once", 64'(done), 64'(0));
      chk("zero_done_cnt", 64'(done_cnt - dc0), 64'(1));
      return;
    end
    s = cyc;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_addr", 64'(ram_rd_addr), 64'(base % 4096));
    chk("start_valid_low", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("valid_low_lat1", 64'(out_valid), 64'(0));
    got = 1'b0;
    for (int k = 0; k < len * 4 + 50 && !got; k++) begin
      @(negedge clk);
      if (k == 0) chk("first_valid", 64'(out_valid), 64'(1));
      if (spur && k == 3) begin
        rd_start     = 1'b1;
        rd_base_addr = AW'(base + 1000);
        rd_length    = (AW + 1)'(7);
      end
      if (spur && k == 4) rd_start = 1'b0;
      if (done) got = 1'b1;
    end
    if (!got) begin
      chk("done_timeout", 64'(got), 64'(1));
      return;
    end
    if (!rnd) chk("done_latency", 64'(cyc - s), 64'(len + 2));
    chk("done_busy_low", 64'(busy), 64'(0));
    chk("all_words_out", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    chk("done_single", 64'(done), 64'(0));
    chk("done_count", 64'(done_cnt - dc0), 64'(1));
    chk("idle_valid", 64'(out_valid), 64'(0));
  endtask

  task automatic reset_mid_run();
    int dc0;
    int r0;
    mode = 1'b0;
    @(posedge clk);
    #1;
    rd_start     = 1'b1;
    rd_base_addr = AW'(12'h300);
    rd_length    = (AW + 1)'(20);
    dc0 = done_cnt;
    r0  = rx_cnt;
    for (int i = 0; i < 20; i++) exp_q.push_back(mem[12'h300 + i]);
    @(posedge clk);
    #1;
    rd_start = 1'b0;
    for (int k = 0; k < 200 && (rx_cnt - r0) < 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_words_before", 64'((rx_cnt - r0) >= 5), 64'(1));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_addr", 64'(ram_rd_addr), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    repeat (30) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - dc0), 64'(0));
    chk("rst_stays_idle", 64'(out_valid), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    rd_start     = 1'b0;
    rd_base_addr = '0;
    rd_length    = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_addr", 64'(ram_rd_addr), 64'(0));
    chk("reset_data", 64'(out_data), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run(12'h010, 4, 1'b0, 1'b0);
    run(12'hFFE, 4, 1'b0, 1'b0);
    run(12'h5A0, 64, 1'b1, 1'b0);
    run(12'h234, 0, 1'b0, 1'b0);
    run(12'h100, 16, 1'b0, 1'b1);
    run(12'h777, 1, 1'b1, 1'b0);
    run(12'h800, 4096, 1'b0, 1'b0);
    reset_mid_run();
    run(12'h123, 20, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      run(int'($urandom_range(0, 4095)), int'($urandom_range(1, 40)),
          1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
